mt9v034_i2c_master: RTL and testbench

//  Parametrised I2C register master for the MT9V034 control bus; replaces the hand-sequenced SDA toggling in the top level.

---
 rtl/mt9v034_i2c_master.sv | 154 +++++++++++++++
 tb/tb_mt9v034_i2c_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mt9v034_i2c_master.sv
// I2C register master for the MT9V034 control bus: START, device + register address, DATA_BYTES data bytes
// (repeated START for reads), ACK checking and STOP; SCL = clk/(4*CLK_DIV), one request at a time.
module mt9v034_i2c_master #(
  parameter int unsigned CLK_DIV    = 120,
  parameter logic [6:0]  DEV_ADDR   = 7'h5C,
  parameter int unsigned DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    rw,
  input  logic [7:0]              reg_addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    ack_err,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    scl_o,
  output logic                    sda_o,
  input  logic                    sda_i
);
  localparam int DW   = 8 * DATA_BYTES;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BYW  = $clog2(DATA_BYTES) + 1;
  localparam logic [DIVW-1:0] DIV_MAX   = DIVW'(CLK_DIV - 1);
  localparam logic [BYW-1:0]  LAST_BYTE = BYW'(DATA_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_AW, S_REG, S_ACK_REG, S_WDATA, S_ACK_WD,
    S_RSTART, S_ADDR_R, S_ACK_AR, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t          state_q;
  logic [DIVW-1:0] div_q;
  logic [1:0]      ph_q;
  logic [2:0]      bit_q;
  logic [BYW-1:0]  byte_q;
  logic [7:0]      tx_q, reg_q;
  logic [DW-1:0]   wdat_q, rx_q, rdata_q;
  logic            rw_q, samp_q, err_q;
  logic            busy_q, done_q, ack_err_q, scl_q, sda_q;
  logic            scl_d, sda_d, tick, slot_end, accept;

  assign tick     = (div_q == DIV_MAX);
  assign slot_end = tick && (ph_q == 2'd3);
  // A request arriving as STOP completes chains straight into the next START with busy held high.
  assign accept   = start && ((state_q == S_IDLE) || (slot_end && state_q == S_STOP));

  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_q)
      S_IDLE:   sda_d = 1'b1;
      S_START:  sda_d = ~ph_q[1];
      S_RSTART: begin scl_d = (ph_q != 2'd0); sda_d = ~ph_q[1]; end
      S_STOP:   begin scl_d = (ph_q != 2'd0); sda_d = ph_q[1];  end
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin scl_d = ph_q[1]; sda_d = tx_q[7]; end
      S_MACK:   begin scl_d = ph_q[1]; sda_d = (byte_q == LAST_BYTE); end
      default:  scl_d = ph_q[1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  div_q  <= '0;  ph_q   <= '0;  bit_q   <= '0;  byte_q <= '0;
      tx_q    <= '0;      reg_q  <= '0;  wdat_q <= '0;  rx_q    <= '0;  rdata_q <= '0;
      rw_q    <= 1'b0;    samp_q <= 1'b1; err_q <= 1'b0;
      busy_q  <= 1'b0;    done_q <= 1'b0; ack_err_q <= 1'b0; scl_q <= 1'b1; sda_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      scl_q  <= scl_d;
      sda_q  <= sda_d;
      if (state_q != S_IDLE) begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) ph_q <= ph_q + 1'b1;
        if (tick && ph_q == 2'd2) begin
          samp_q <= sda_i;
          if (state_q == S_RDATA) rx_q <= {rx_q[DW-2:0], sda_i};
        end
        if (slot_end) begin
          case (state_q)
            S_START: begin state_q <= S_ADDR_W; tx_q <= {DEV_ADDR, 1'b0}; end
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
              tx_q  <= {tx_q[6:0], 1'b0};
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) begin
                case (state_q)
                  S_ADDR_W: state_q <= S_ACK_AW;
                  S_REG:    state_q <= S_ACK_REG;
                  S_WDATA:  state_q <= S_ACK_WD;
                  default:  state_q <= S_ACK_AR;
                endcase
              end
            end
            S_ACK_AW, S_ACK_REG, S_ACK_WD, S_ACK_AR: begin
              if (samp_q) begin
                err_q   <= 1'b1;
                state_q <= S_STOP;
              end else begin
                case (state_q)
                  S_ACK_AW: begin state_q <= S_REG; tx_q <= reg_q; end
                  S_ACK_REG: begin
                    if (rw_q) state_q <= S_RSTART;
                    else begin
                      state_q <= S_WDATA;  tx_q <= wdat_q[DW-1 -: 8];
                      wdat_q  <= wdat_q << 8; byte_q <= '0;
                    end
                  end
                  S_ACK_WD: begin
                    if (byte_q == LAST_BYTE) state_q <= S_STOP;
                    else begin
                      state_q <= S_WDATA;  tx_q <= wdat_q[DW-1 -: 8];
                      wdat_q  <= wdat_q << 8; byte_q <= byte_q + 1'b1;
                    end
                  end
                  default: begin state_q <= S_RDATA; byte_q <= '0; end
                endcase
              end
            end
            S_RSTART: begin state_q <= S_ADDR_R; tx_q <= {DEV_ADDR, 1'b1}; end
            S_RDATA: begin
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= S_MACK;
            end
            S_MACK: begin
              if (byte_q == LAST_BYTE) state_q <= S_STOP;
              else begin state_q <= S_RDATA; byte_q <= byte_q + 1'b1; end
            end
            S_STOP: begin
              done_q    <= 1'b1;
              ack_err_q <= err_q;
              if (!err_q && rw_q) rdata_q <= rx_q;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
      if (accept) begin
        state_q <= S_START;  busy_q <= 1'b1;  div_q <= '0;  ph_q <= '0;
        bit_q   <= '0;       byte_q <= '0;    err_q <= 1'b0;
        rw_q    <= rw;       reg_q  <= reg_addr; wdat_q <= wdata;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl_o   = scl_q;
  assign sda_o   = sda_q;
endmodule

// File: tb/tb_mt9v034_i2c_master.sv
// Bench for mt9v034_i2c_master: a behavioural I2C slave logs the wire and is compared with a protocol-level model.
module tb_mt9v034_i2c_master;
  localparam int SLOT = 16;
  localparam int DB   = 2;
  localparam int EV_START = 1000;
  localparam int EV_STOP  = 2000;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, rw = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, ack_err, scl_o, sda_o, sda_i;
  logic [15:0] rdata;
  logic        slv_sda = 1'b1;

  assign sda_i = sda_o & slv_sda;

  mt9v034_i2c_master #(.CLK_DIV(4), .DEV_ADDR(7'h5C), .DATA_BYTES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int log_q[$], exp_q[$];
  bit active = 0, rdmode = 0, addr_byte = 0;
  int bitn = -1, wcount = 0, rcount = 0, nack_idx = -1;
  logic [7:0] sh = '0;
  logic [7:0] rd_bytes [DB];

  int          res_cyc, res_ndone;
  logic        res_err, res_busy;
  logic [15:0] res_rdata;

  // Behavioural slave: decodes START/STOP/bytes from the wire, ACKs written bytes, serves read bytes.
  initial begin
    logic pscl, psda, wsda;
    bit reading;
    pscl = 1'b1; psda = 1'b1;
    forever begin
      @(negedge clk);
      wsda = sda_o & slv_sda;
      if (pscl && scl_o && psda && !wsda) begin
        active = 1; bitn = -1; addr_byte = 1; log_q.push_back(EV_START);
      end else if (pscl && scl_o && !psda && wsda && active) begin
        active = 0; slv_sda = 1'b1; log_q.push_back(EV_STOP);
      end else if (active && !pscl && scl_o) begin
        if (bitn >= 0 && bitn < 8) sh = {sh[6:0], wsda};
        else if (bitn == 8) begin
          log_q.push_back((int'(wsda) << 8) | int'(sh));
          if (addr_byte) begin rdmode = sh[0] && !wsda; addr_byte = 0; wcount++; end
          else if (rdmode) rcount++;
          else wcount++;
        end
      end else if (active && pscl && !scl_o) begin
        bitn = (bitn == 8) ? 0 : bitn + 1;
        reading = rdmode && !addr_byte;
        if (bitn < 8) slv_sda = (reading && rcount < DB) ? rd_bytes[rcount][7-bitn] : 1'b1;
        else          slv_sda = (!reading && wcount != nack_idx) ? 1'b0 : 1'b1;
      end
      pscl = scl_o;
      psda = wsda;
    end
  end

  task automatic slave_clear();
    log_q.delete();
    active = 0; bitn = -1; wcount = 0; rcount = 0; rdmode = 0; addr_byte = 0; slv_sda = 1'b1;
  endtask

  // Protocol-level reference: appends the expected wire log and returns duration and error flag.
  task automatic model(input logic r, input logic [7:0] ra, input logic [15:0] wd, input logic [15:0] rd,
                       input int nk, output int cyc, output logic err);
    logic [7:0] mb[$];
    int slots;
    mb.push_back(8'hB8); mb.push_back(ra);
    if (r) mb.push_back(8'hB9);
    else begin mb.push_back(wd[15:8]); mb.push_back(wd[7:0]); end
    err = 1'b0; slots = 1;
    exp_q.push_back(EV_START);
    for (int i = 0; i < mb.size(); i++) begin
      if (r && i == 2) begin exp_q.push_back(EV_START); slots++; end
      exp_q.push_back(((i == nk) ? 256 : 0) | int'(mb[i]));
      slots += 9;
      if (i == nk) begin err = 1'b1; break; end
    end
    if (!err && r) begin
      exp_q.push_back(int'(rd[15:8]));
      exp_q.push_back(256 | int'(rd[7:0]));
      slots += 18;
    end
    exp_q.push_back(EV_STOP);
    slots++;
    cyc = slots * SLOT;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int log_mismatch();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] != exp_q[i]) return i;
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic run_txn(input logic r, input logic [7:0] ra, input logic [15:0] wd, input logic [15:0] rd,
                         input int nk, input int rep);
    int first;
    slave_clear();
    rd_bytes[0] = rd[15:8]; rd_bytes[1] = rd[7:0]; nack_idx = nk;
    @(negedge clk); start = 1'b1; rw = r; reg_addr = ra; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; rw = ~r; reg_addr = ~ra; wdata = ~wd;
    first = 0; res_ndone = 0; res_err = 1'b0; res_rdata = '0; res_busy = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      start = (rep != 0 && c == rep);
      @(posedge clk); #1;
      if (done) begin
        res_ndone++;
        if (first == 0) begin first = c; res_err = ack_err; res_rdata = rdata; res_busy = busy; end
      end
      if (first != 0 && c >= first + 40) break;
    end
    start = 1'b0;
    res_cyc = first;
  endtask

  task automatic check_txn(input string tag, input logic r, input logic [7:0] ra, input logic [15:0] wd,
                           input logic [15:0] rd, input int nk, input int rep,
                           input logic e_err, input int e_cyc, input logic [15:0] e_rdata);
    run_txn(r, ra, wd, rd, nk, rep);
    chk({tag, ".latency"}, res_cyc, e_cyc);
    chk({tag, ".ack_err"}, int'(res_err), int'(e_err));
    chk({tag, ".rdata"}, int'(res_rdata), int'(e_rdata));
    chk({tag, ".done_pulses"}, res_ndone, 1);
    chk({tag, ".busy_at_done"}, int'(res_busy), 0);
    chk({tag, ".wire_log"}, log_mismatch(), -1);
  endtask

  typedef struct {
    logic        r;
    logic [7:0]  ra;
    logic [15:0] wd;
    logic [15:0] rd;
    int          nk;
    logic        e_err;
    int          e_cyc;
    logic [15:0] e_rdata;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [15:0] m_rdata;
    int mc, gaps, nd, first, second;
    logic me, b2b_busy;

    vecs[0] = '{1'b0, 8'h07, 16'h0388, 16'h0000, -1, 1'b0, 608, 16'h0000};
    vecs[1] = '{1'b1, 8'h00, 16'h0000, 16'h1324, -1, 1'b0, 768, 16'h1324};
    vecs[2] = '{1'b1, 8'h55, 16'h0000, 16'hBEEF,  0, 1'b1, 176, 16'h1324};
    vecs[3] = '{1'b0, 8'h3A, 16'hA5C3, 16'h0000,  3, 1'b1, 608, 16'h1324};
    vecs[4] = '{1'b1, 8'h10, 16'h0000, 16'h0F0F,  2, 1'b1, 480, 16'h1324};
    vecs[5] = '{1'b1, 8'h81, 16'h0000, 16'hFF01, -1, 1'b0, 768, 16'hFF01};
    vecs[6] = '{1'b0, 8'h20, 16'h1234, 16'h0000,  1, 1'b1, 320, 16'hFF01};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.scl", int'(scl_o), 1);
    chk("reset.sda", int'(sda_o), 1);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.ack_err", int'(ack_err), 0);
    chk("reset.rdata", int'(rdata), 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      exp_q.delete();
      model(vecs[i].r, vecs[i].ra, vecs[i].wd, vecs[i].rd, vecs[i].nk, mc, me);
      check_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].ra, vecs[i].wd, vecs[i].rd, vecs[i].nk, 0,
                vecs[i].e_err, vecs[i].e_cyc, vecs[i].e_rdata);
    end
    m_rdata = 16'hFF01;

    for (int i = 0; i < 10; i++) begin
      logic r;
      logic [7:0] ra;
      logic [15:0] wd, rd;
      int nk;
      r  = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      wd = 16'($urandom);
      rd = 16'($urandom);
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r ? 2 : 3)) : -1;
      exp_q.delete();
      model(r, ra, wd, rd, nk, mc, me);
      if (r && !me) m_rdata = rd;
      check_txn($sformatf("rnd%0d", i), r, ra, wd, rd, nk, 0, me, mc, m_rdata);
    end

    // A second start 100 clk into a write must be dropped.
    exp_q.delete();
    model(1'b0, 8'h07, 16'h0388, 16'h0000, -1, mc, me);
    check_txn("repulse", 1'b0, 8'h07, 16'h0388, 16'h0000, -1, 100, 1'b0, 608, m_rdata);

    // Reset during the third bit of the register byte.
    slave_clear(); nack_idx = -1;
    @(negedge clk); start = 1'b1; rw = 1'b0; reg_addr = 8'h07; wdata = 16'h0388;
    @(posedge clk); #1; start = 1'b0;
    repeat (196) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset.scl", int'(scl_o), 1);
    chk("midreset.sda", int'(sda_o), 1);
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.done", int'(done), 0);
    chk("midreset.rdata", int'(rdata), 0);
    reset_n = 1'b1;
    nd = 0;
    repeat (30) begin @(posedge clk); #1; if (done) nd++; end
    chk("midreset.no_done", nd, 0);
    exp_q.delete();
    model(1'b1, 8'h42, 16'h0000, 16'hC35A, -1, mc, me);
    check_txn("after_reset", 1'b1, 8'h42, 16'h0000, 16'hC35A, -1, 0, 1'b0, 768, 16'hC35A);

    // Back-to-back: start held high across the first done.
    slave_clear(); nack_idx = -1;
    exp_q.delete();
    model(1'b0, 8'h11, 16'h2233, 16'h0000, -1, mc, me);
    model(1'b0, 8'h11, 16'h2233, 16'h0000, -1, mc, me);
    @(negedge clk); start = 1'b1; rw = 1'b0; reg_addr = 8'h11; wdata = 16'h2233;
    @(posedge clk); #1;
    gaps = 0; nd = 0; first = 0; second = 0; b2b_busy = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) begin first = c; b2b_busy = busy; start = 1'b0; end
        else begin second = c; break; end
      end else if (!busy) gaps++;
    end
    start = 1'b0;
    chk("b2b.first_latency", first, 608);
    chk("b2b.second_latency", second - first, 608);
    chk("b2b.busy_at_done", int'(b2b_busy), 1);
    chk("b2b.busy_gaps", gaps, 0);
    chk("b2b.wire_log", log_mismatch(), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
